// File: rtl/seq_match_counter_if.sv
// Bundle between the sequence detector side and the match counter: match/clr in,
// BCD count, event pulse and run statistics out.
interface seq_match_counter_if #(
  parameter int RUN_W = 4
);
  logic             match;
  logic             clr;
  logic [7:0]       count_bcd;
  logic             event_pulse;
  logic [RUN_W-1:0] run_len;
  logic             active;
  logic             overflow;

  modport master (
    output match, clr,
    input  count_bcd, event_pulse, run_len, active, overflow
  );

  modport slave (
    input  match, clr,
    output count_bcd, event_pulse, run_len, active, overflow
  );
endinterface

// File: rtl/seq_match_counter.sv
// Turns the detector's match level into counted events: 2-digit BCD event count,
// one-cycle event pulse, run-length of the last match run and sticky overflow.
module seq_match_counter #(
  parameter int RUN_W = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  seq_match_counter_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       units_q, units_d;
  logic             event_q, event_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic             active_q, active_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tens_q    <= '0;
      units_q   <= '0;
      event_q   <= 1'b0;
      run_q     <= '0;
      run_len_q <= '0;
      active_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      event_q   <= event_d;
      run_q     <= run_d;
      run_len_q <= run_len_d;
      active_q  <= active_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    units_d   = units_q;
    event_d   = 1'b0;
    run_d     = run_q;
    run_len_d = run_len_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.match) begin
          state_d = ACTIVE;
          event_d = 1'b1;
          run_d   = RUN_W'(1);
          if (units_q != 4'd9) begin
            units_d = units_q + 4'd1;
          end else if (tens_q != 4'd9) begin
            units_d = 4'd0;
            tens_d  = tens_q + 4'd1;
          end else begin
            // 99 + 1: either roll to 00 or pin at 99, overflow either way
            units_d = WRAP ? 4'd0 : 4'd9;
            tens_d  = WRAP ? 4'd0 : 4'd9;
            ovf_d   = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (bus.match) begin
          if (run_q != {RUN_W{1'b1}}) run_d = run_q + RUN_W'(1);
        end else begin
          state_d   = IDLE;
          run_len_d = run_q;
          run_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // clear leaves FSM and run counter alone so an open run still reports fully
    if (bus.clr) begin
      tens_d    = '0;
      units_d   = '0;
      ovf_d     = 1'b0;
      run_len_d = '0;
    end

    active_d = (state_d == ACTIVE);
  end

  assign bus.count_bcd   = {tens_q, units_q};
  assign bus.event_pulse = event_q;
  assign bus.run_len     = run_len_q;
  assign bus.active      = active_q;
  assign bus.overflow    = ovf_q;

endmodule
